pipe_ctrl_seq: RTL and testbench

- Central stall/flush/drain sequencer for the 5-stage PA-RISC pipeline.
- Inputs: the data-hazard unit's load-use stall request, the EX-stage branch outcome (taken/nullify), data-memory busy, and a halt request.
- Outputs: per-stage register load enables, the IF/ID flush, and the ID/EX bubble.
- Sits beside the hazard unit; its outputs replace the raw hazard-unit LE/NOP at the pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_ctrl_seq_sat_counter.sv | 16 +
 rtl/pipe_ctrl_seq.sv | 99 +++++++++
 tb/tb_pipe_ctrl_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encoding and default constants shared by the pipeline sequencer
package pipe_ctrl_pkg;
  typedef enum logic [2:0] {
    RESET_WAIT = 3'd0,
    RUN        = 3'd1,
    LOAD_STALL = 3'd2,
    MEM_WAIT   = 3'd3,
    DRAIN      = 3'd4,
    HALTED     = 3'd5
  } state_t;
  localparam int DRAIN_CYC_DEF = 4;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/pipe_ctrl_seq_sat_counter.sv
// sat_counter: up counter that sticks at all-ones, with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);
  // count on inc until every bit is set, then hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= '0;
    else if (clear) value <= '0;
    else if (inc && value != '1) value <= value + W'(1);
endmodule

// File: rtl/pipe_ctrl_seq.sv
// pipe_ctrl_seq: stall/flush/drain sequencer for the 5-stage pipeline; PIPE_CTRL_PERF_EN adds flush/bubble counters
module pipe_ctrl_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             br_taken,
  input  logic             br_nullify,
  input  logic             mem_busy,
  input  logic             halt_req,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             ifid_clr,
  output logic             idex_nop,
  output logic             ex_le,
  output logic             memwb_le,
  output logic             halted,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
`endif
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  state_t st, nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic stall_inc;
  // state and drain counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= RESET_WAIT;
      dcnt <= '0;
    end else begin
      st <= nxt;
      dcnt <= dcnt_nxt;
    end
  // next state and combinational enables; memory wait always wins, branches beat load-use, halt is last
  always_comb begin
    nxt = st;
    dcnt_nxt = dcnt;
    {pc_le, ifid_le, ifid_clr, idex_nop, ex_le, memwb_le, halted} = '0;
    case (st)
      RESET_WAIT: nxt = RUN;
      RUN, LOAD_STALL:
        if (mem_busy) nxt = MEM_WAIT;
        else begin
          nxt = RUN;
          {pc_le, ifid_le, ex_le, memwb_le} = '1;
          if (br_taken) begin
            ifid_clr = 1'b1;
            idex_nop = br_nullify;
          end else if (br_nullify) idex_nop = 1'b1;
          else if (st == RUN && hz_stall) begin
            pc_le = 1'b0;
            ifid_le = 1'b0;
            idex_nop = 1'b1;
            nxt = LOAD_STALL;
          end else if (st == RUN && halt_req) begin
            pc_le = 1'b0;
            ifid_clr = 1'b1;
            nxt = DRAIN;
            dcnt_nxt = DW'(DRAIN_CYC - 1);
          end
        end
      MEM_WAIT:
        if (!mem_busy) begin
          {pc_le, ifid_le, ex_le, memwb_le} = '1;
          nxt = RUN;
        end
      DRAIN:
        if (!mem_busy) begin
          {ifid_le, ifid_clr, ex_le, memwb_le} = '1;
          nxt = (dcnt == '0) ? HALTED : DRAIN;
          dcnt_nxt = (dcnt == '0) ? dcnt : dcnt - DW'(1);
        end
      HALTED: begin
        halted = 1'b1;
        nxt = halt_req ? HALTED : RUN;
      end
      default: nxt = RESET_WAIT;
    endcase
  end
  assign stall_inc = !pc_le && (st == RUN || st == LOAD_STALL || st == MEM_WAIT || st == DRAIN);
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .inc(stall_inc), .value(stall_cnt)
  );
`ifdef PIPE_CTRL_PERF_EN
  sat_counter #(.W(CNT_W)) u_flush (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .inc(ifid_clr && st == RUN), .value(flush_cnt)
  );
  sat_counter #(.W(CNT_W)) u_bubble (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .inc(idex_nop), .value(bubble_cnt)
  );
`endif
endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// tb_pipe_ctrl_seq: directed literal checks plus randomized run against a behavioural sequencer model
module tb_pipe_ctrl_seq;
  localparam int DRAIN_CYC = 4;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 0;
  logic rst_n, hz_stall, br_taken, br_nullify, mem_busy, halt_req;
  logic pc_le, ifid_le, ifid_clr, idex_nop, ex_le, memwb_le, halted;
  logic [CNT_W-1:0] stall_cnt;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] flush_cnt, bubble_cnt;
`endif
  int checks = 0, errors = 0;
  pipe_ctrl_seq #(.DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .br_taken(br_taken),
    .br_nullify(br_nullify), .mem_busy(mem_busy), .halt_req(halt_req),
    .pc_le(pc_le), .ifid_le(ifid_le), .ifid_clr(ifid_clr), .idex_nop(idex_nop),
    .ex_le(ex_le), .memwb_le(memwb_le), .halted(halted),
`ifdef PIPE_CTRL_PERF_EN
    .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt),
`endif
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  // model: condition flags instead of a state machine, counters as plain integers
  bit m_fresh = 1, m_wait = 0, m_ls = 0, m_halt = 0;
  int m_drain = -1, m_stall = 0, m_flush = 0, m_bub = 0;
  bit n_wait, n_ls, n_halt, si, fi;
  int n_drain;
  logic [6:0] e;
  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction
  // compute what this cycle's outputs must be, compare, and prepare the model's next step
  always @(negedge clk) begin
    e = '0; si = 0; fi = 0;
    n_wait = m_wait; n_ls = 0; n_halt = m_halt; n_drain = m_drain;
    if (!rst_n || m_fresh) e = '0;
    else if (m_halt) begin
      e[0] = 1;
      n_halt = halt_req;
    end else if (m_drain >= 0) begin
      si = 1;
      if (!mem_busy) begin
        e = 7'b0110110;
        si = 1;
        n_drain = m_drain - 1;
        n_halt = (m_drain == 0);
      end
    end else if (m_wait) begin
      if (mem_busy) si = 1;
      else begin
        e = 7'b1100110;
        n_wait = 0;
      end
    end else if (mem_busy) begin
      si = 1;
      n_wait = 1;
    end else begin
      e = 7'b1100110;
      if (br_taken) e[4:3] = {1'b1, br_nullify};
      else if (br_nullify) e[3] = 1;
      else if (!m_ls && hz_stall) begin
        e = 7'b0001110;
        n_ls = 1;
        si = 1;
      end else if (!m_ls && halt_req) begin
        e = 7'b0110110;
        n_drain = DRAIN_CYC - 1;
        si = 1;
      end
      fi = e[4] && !m_ls;
    end
    checks++;
    if ({pc_le, ifid_le, ifid_clr, idex_nop, ex_le, memwb_le, halted} !== e ||
        stall_cnt !== CNT_W'(rst_n ? m_stall : 0)) begin
      errors++;
      $display("FAIL model_cmp t=%0t outs=%b want=%b stall_cnt=%0d want=%0d", $time,
               {pc_le, ifid_le, ifid_clr, idex_nop, ex_le, memwb_le, halted}, e, stall_cnt, rst_n ? m_stall : 0);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (flush_cnt !== CNT_W'(rst_n ? m_flush : 0) || bubble_cnt !== CNT_W'(rst_n ? m_bub : 0)) begin
      errors++;
      $display("FAIL perf_cmp t=%0t flush=%0d want=%0d bubble=%0d want=%0d", $time,
               flush_cnt, m_flush, bubble_cnt, m_bub);
    end
`endif
  end
  // advance the model on the clock, clear it on reset
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_fresh <= 1; m_wait <= 0; m_ls <= 0; m_halt <= 0; m_drain <= -1;
      m_stall <= 0; m_flush <= 0; m_bub <= 0;
    end else begin
      m_fresh <= 0; m_wait <= n_wait; m_ls <= n_ls; m_halt <= n_halt; m_drain <= n_drain;
      m_stall <= sat(m_stall + int'(si));
      m_flush <= sat(m_flush + int'(fi));
      m_bub <= sat(m_bub + int'(e[3]));
    end
  // v = {hz_stall, br_taken, br_nullify, mem_busy, halt_req}
  task automatic cyc(input logic [4:0] v);
    @(posedge clk);
    #1 {hz_stall, br_taken, br_nullify, mem_busy, halt_req} = v;
  endtask
  task automatic lit(input string nm, input logic [6:0] xo, input int xc);
    #2 checks++;
    if ({pc_le, ifid_le, ifid_clr, idex_nop, ex_le, memwb_le, halted} !== xo || stall_cnt !== CNT_W'(xc)) begin
      errors++;
      $display("FAIL %s outs=%b want=%b stall_cnt=%0d want=%0d", nm,
               {pc_le, ifid_le, ifid_clr, idex_nop, ex_le, memwb_le, halted}, xo, stall_cnt, xc);
    end
  endtask
  initial begin
    rst_n = 0;
    {hz_stall, br_taken, br_nullify, mem_busy, halt_req} = '0;
    repeat (3) cyc(5'b00000);
    lit("in_reset", 7'b0000000, 0);
    @(posedge clk); #1 rst_n = 1;
    lit("reset_wait", 7'b0000000, 0);
    cyc(5'b00000); lit("run", 7'b1100110, 0);
    cyc(5'b10000); lit("load_use", 7'b0001110, 0);
    cyc(5'b00000); lit("load_stall", 7'b1100110, 1);
    cyc(5'b00000); lit("after_ls", 7'b1100110, 1);
    cyc(5'b11100); lit("br_hz_null", 7'b1111110, 1);
    cyc(5'b00000); lit("no_ls_entry", 7'b1100110, 1);
    cyc(5'b00010); lit("mem_busy1", 7'b0000000, 1);
    cyc(5'b01010); lit("mem_busy2_br", 7'b0000000, 2);
    cyc(5'b00010); lit("mem_busy3", 7'b0000000, 3);
    cyc(5'b00000); lit("mem_release", 7'b1100110, 4);
    cyc(5'b00000); lit("run_again", 7'b1100110, 4);
    cyc(5'b00001); lit("halt_req", 7'b0110110, 4);
    for (int i = 0; i < DRAIN_CYC; i++) begin
      cyc(5'b00001); lit("drain", 7'b0110110, 5 + i);
    end
    cyc(5'b00001); lit("halted", 7'b0000001, 9);
    cyc(5'b00000); lit("halt_release", 7'b0000001, 9);
    cyc(5'b00000); lit("resume", 7'b1100110, 9);
    cyc(5'b00001); lit("halt_req2", 7'b0110110, 9);
    cyc(5'b00001); lit("drain2", 7'b0110110, 10);
    rst_n = 0;
    lit("async_reset", 7'b0000000, 0);
    cyc(5'b00000);
    @(posedge clk); #1 rst_n = 1;
    lit("reset_wait2", 7'b0000000, 0);
    cyc(5'b01000); lit("br1", 7'b1110110, 0);
    cyc(5'b01000); lit("br2", 7'b1110110, 0);
    cyc(5'b10000); lit("ls_perf", 7'b0001110, 0);
    cyc(5'b00000); lit("ls_perf_next", 7'b1100110, 1);
    cyc(5'b00000);
`ifdef PIPE_CTRL_PERF_EN
    #2 checks++;
    if (flush_cnt !== CNT_W'(2) || bubble_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL perf_lit flush=%0d want=2 bubble=%0d want=1", flush_cnt, bubble_cnt);
    end
`else
    #2 checks++;
    if (stall_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL stall_lit stall_cnt=%0d want=1", stall_cnt);
    end
`endif
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1 rst_n = ($urandom_range(0, 499) != 0);
      hz_stall = ($urandom_range(0, 3) == 0);
      br_taken = ($urandom_range(0, 7) == 0);
      br_nullify = ($urandom_range(0, 7) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 24) == 0) halt_req = !halt_req;
    end
    @(posedge clk); #1 rst_n = 1;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
